rs_issue_sched: RTL and testbench

- Reservation-station scheduler for the out-of-order core. Holds up to ENTRIES micro-ops waiting on source operands.
- Allocates the lowest-index free slot and tracks operand readiness via tag wakeup broadcasts.
- Selects the lowest-index fully-ready entry into a registered issue stage with valid/ready handshake.
- Uses the same lowest-index priority-select rule as the core's priority encoder: value ENTRIES means "none found".

---
 rtl/rs_issue_sched.sv | 142 ++++++++++++++
 tb/tb_rs_issue_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - reservation-station scheduler with tag wakeup and registered issue stage
//
// Holds up to ENTRIES micro-ops waiting on two source operands each.
// Dispatch writes into the lowest-index free slot. A result-tag broadcast
// sets the matching source ready bits. The lowest-index entry with both
// sources ready moves into a one-deep issue register that uses a
// valid/ready handshake.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   flush_i             clears the station and the issue register
//   alloc_*             dispatch side: valid/ready, payload, source tags and ready bits,
//                       alloc_index_o = slot used on accept (ENTRIES when full)
//   wake_valid_i/tag_i  one result-tag broadcast per cycle
//   issue_*             functional-unit side: valid/ready, payload, source slot index
//   occupancy_o         occupied slots, not counting the issue register
module rs_issue_sched #(
    parameter int ENTRIES   = 32,
    parameter int IDX_W     = 6,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 alloc_valid_i,
    output logic                 alloc_ready_o,
    input  logic [PAYLOAD_W-1:0] alloc_payload_i,
    input  logic [TAG_W-1:0]     alloc_src1_tag_i,
    input  logic                 alloc_src1_rdy_i,
    input  logic [TAG_W-1:0]     alloc_src2_tag_i,
    input  logic                 alloc_src2_rdy_i,
    output logic [IDX_W-1:0]     alloc_index_o,
    input  logic                 wake_valid_i,
    input  logic [TAG_W-1:0]     wake_tag_i,
    output logic                 issue_valid_o,
    input  logic                 issue_ready_i,
    output logic [PAYLOAD_W-1:0] issue_payload_o,
    output logic [IDX_W-1:0]     issue_index_o,
    output logic [IDX_W-1:0]     occupancy_o
);

    localparam int SLOT_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [IDX_W-1:0] NONE = IDX_W'(ENTRIES);

    logic [ENTRIES-1:0]   slot_valid;
    logic [ENTRIES-1:0]   src1_rdy;
    logic [ENTRIES-1:0]   src2_rdy;
    logic [PAYLOAD_W-1:0] slot_payload [ENTRIES];
    logic [TAG_W-1:0]     src1_tag     [ENTRIES];
    logic [TAG_W-1:0]     src2_tag     [ENTRIES];

    logic [ENTRIES-1:0]   eligible;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     sel_idx;
    logic [SLOT_W-1:0]    free_slot;
    logic [SLOT_W-1:0]    sel_slot;
    logic                 sel_found;
    logic                 accept;
    logic                 stage_open;
    logic                 advance;
    logic                 new_src1_rdy;
    logic                 new_src2_rdy;

    // Both priority encoders look at registered state only, so a slot being
    // written this cycle can neither be selected nor re-offered as free.
    always_comb begin
        eligible = slot_valid & src1_rdy & src2_rdy;
        free_idx = NONE;
        sel_idx  = NONE;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_idx = IDX_W'(i);
            end
            if (eligible[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign free_slot     = free_idx[SLOT_W-1:0];
    assign sel_slot      = sel_idx[SLOT_W-1:0];
    assign sel_found     = |eligible;

    assign alloc_index_o = free_idx;
    assign alloc_ready_o = (free_idx != NONE) && !flush_i;
    assign accept        = alloc_valid_i && alloc_ready_o;

    // The issue register can take a new op when empty or when its op leaves now.
    assign stage_open    = !issue_valid_o || issue_ready_i;
    assign advance       = stage_open && sel_found;

    // A broadcast in the allocation cycle would otherwise be missed by the new slot.
    assign new_src1_rdy  = alloc_src1_rdy_i || (wake_valid_i && (wake_tag_i == alloc_src1_tag_i));
    assign new_src2_rdy  = alloc_src2_rdy_i || (wake_valid_i && (wake_tag_i == alloc_src2_tag_i));

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            slot_valid      <= '0;
            src1_rdy        <= '0;
            src2_rdy        <= '0;
            issue_valid_o   <= 1'b0;
            issue_payload_o <= '0;
            issue_index_o   <= '0;
            occupancy_o     <= '0;
        end else begin
            if (wake_valid_i) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (slot_valid[i] && (src1_tag[i] == wake_tag_i)) begin
                        src1_rdy[i] <= 1'b1;
                    end
                    if (slot_valid[i] && (src2_tag[i] == wake_tag_i)) begin
                        src2_rdy[i] <= 1'b1;
                    end
                end
            end

            // The allocated slot is free and the selected slot is occupied,
            // so these two updates never touch the same entry.
            if (accept) begin
                slot_valid[free_slot]   <= 1'b1;
                slot_payload[free_slot] <= alloc_payload_i;
                src1_tag[free_slot]     <= alloc_src1_tag_i;
                src2_tag[free_slot]     <= alloc_src2_tag_i;
                src1_rdy[free_slot]     <= new_src1_rdy;
                src2_rdy[free_slot]     <= new_src2_rdy;
            end

            if (advance) begin
                slot_valid[sel_slot] <= 1'b0;
                issue_valid_o        <= 1'b1;
                issue_payload_o      <= slot_payload[sel_slot];
                issue_index_o        <= sel_idx;
            end else if (stage_open) begin
                issue_valid_o <= 1'b0;
            end

            occupancy_o <= occupancy_o + IDX_W'(accept) - IDX_W'(advance);
        end
    end

endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - self-checking bench for rs_issue_sched
module tb_rs_issue_sched;

    localparam int ENTRIES   = 32;
    localparam int IDX_W     = 6;
    localparam int TAG_W     = 6;
    localparam int PAYLOAD_W = 32;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic                 flush_i;
    logic                 alloc_valid_i;
    logic                 alloc_ready_o;
    logic [PAYLOAD_W-1:0] alloc_payload_i;
    logic [TAG_W-1:0]     alloc_src1_tag_i;
    logic                 alloc_src1_rdy_i;
    logic [TAG_W-1:0]     alloc_src2_tag_i;
    logic                 alloc_src2_rdy_i;
    logic [IDX_W-1:0]     alloc_index_o;
    logic                 wake_valid_i;
    logic [TAG_W-1:0]     wake_tag_i;
    logic                 issue_valid_o;
    logic                 issue_ready_i;
    logic [PAYLOAD_W-1:0] issue_payload_o;
    logic [IDX_W-1:0]     issue_index_o;
    logic [IDX_W-1:0]     occupancy_o;

    rs_issue_sched #(
        .ENTRIES  (ENTRIES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .flush_i         (flush_i),
        .alloc_valid_i   (alloc_valid_i),
        .alloc_ready_o   (alloc_ready_o),
        .alloc_payload_i (alloc_payload_i),
        .alloc_src1_tag_i(alloc_src1_tag_i),
        .alloc_src1_rdy_i(alloc_src1_rdy_i),
        .alloc_src2_tag_i(alloc_src2_tag_i),
        .alloc_src2_rdy_i(alloc_src2_rdy_i),
        .alloc_index_o   (alloc_index_o),
        .wake_valid_i    (wake_valid_i),
        .wake_tag_i      (wake_tag_i),
        .issue_valid_o   (issue_valid_o),
        .issue_ready_i   (issue_ready_i),
        .issue_payload_o (issue_payload_o),
        .issue_index_o   (issue_index_o),
        .occupancy_o     (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected issue stream: {payload, slot index}
    logic [PAYLOAD_W+IDX_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_alloc(input logic [PAYLOAD_W-1:0] p,
                               input logic [TAG_W-1:0] t1, input logic r1,
                               input logic [TAG_W-1:0] t2, input logic r2);
        alloc_valid_i    = 1'b1;
        alloc_payload_i  = p;
        alloc_src1_tag_i = t1;
        alloc_src1_rdy_i = r1;
        alloc_src2_tag_i = t2;
        alloc_src2_rdy_i = r2;
    endtask

    task automatic expect_issue(input logic [PAYLOAD_W-1:0] p, input int idx);
        exp_q.push_back({p, IDX_W'(idx)});
    endtask

    // Scoreboard: every completed issue handshake must match the next expected op.
    always @(negedge clk_i) begin
        if (!reset_i && !flush_i) begin
            if (issue_valid_o && issue_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_issue", {58'd0, issue_index_o}, 64'd99);
                end else begin
                    check("sb_issue", {26'd0, issue_payload_o, issue_index_o}, {26'd0, exp_q.pop_front()});
                end
            end
            if (occupancy_o > IDX_W'(ENTRIES)) begin
                check("occ_bound", {58'd0, occupancy_o}, ENTRIES);
            end
        end
    end

    initial begin
        int n;
        reset_i          = 1'b1;
        flush_i          = 1'b0;
        alloc_valid_i    = 1'b0;
        alloc_payload_i  = '0;
        alloc_src1_tag_i = '0;
        alloc_src1_rdy_i = 1'b0;
        alloc_src2_tag_i = '0;
        alloc_src2_rdy_i = 1'b0;
        wake_valid_i     = 1'b0;
        wake_tag_i       = '0;
        issue_ready_i    = 1'b1;

        // Reset
        step();
        step();
        reset_i = 1'b0;
        check("rst_alloc_ready", alloc_ready_o, 1);
        check("rst_alloc_index", alloc_index_o, 0);
        check("rst_issue_valid", issue_valid_o, 0);
        check("rst_occupancy", occupancy_o, 0);

        // In-order ready ops; slot 0 is freed when A issues so C reuses it
        drive_alloc(32'hA, 6'd1, 1'b1, 6'd2, 1'b1);
        expect_issue(32'hA, 0);
        step();
        check("ino_valid_e1", issue_valid_o, 0);
        check("ino_occ_e1", occupancy_o, 1);
        drive_alloc(32'hB, 6'd1, 1'b1, 6'd2, 1'b1);
        expect_issue(32'hB, 1);
        step();
        check("ino_valid_e2", issue_valid_o, 1);
        check("ino_payload_e2", issue_payload_o, 32'hA);
        check("ino_occ_e2", occupancy_o, 1);
        check("ino_free_idx_e2", alloc_index_o, 0);
        drive_alloc(32'hC, 6'd1, 1'b1, 6'd2, 1'b1);
        expect_issue(32'hC, 0);
        step();
        alloc_valid_i = 1'b0;
        check("ino_payload_e3", issue_payload_o, 32'hB);
        check("ino_occ_e3", occupancy_o, 1);
        step();
        check("ino_payload_e4", issue_payload_o, 32'hC);
        check("ino_index_e4", issue_index_o, 0);
        check("ino_occ_e4", occupancy_o, 0);
        step();
        check("ino_drained", issue_valid_o, 0);

        // Fill all slots waiting on tag 5, then wake
        for (int i = 0; i < ENTRIES; i++) begin
            drive_alloc(32'h100 + i, 6'd5, 1'b0, 6'd9, 1'b1);
            expect_issue(32'h100 + i, i);
            step();
        end
        alloc_valid_i = 1'b0;
        check("full_alloc_ready", alloc_ready_o, 0);
        check("full_alloc_index", alloc_index_o, ENTRIES);
        check("full_occupancy", occupancy_o, ENTRIES);
        check("full_no_issue", issue_valid_o, 0);
        wake_valid_i = 1'b1;
        wake_tag_i   = 6'd5;
        step();
        wake_valid_i = 1'b0;
        check("wake_no_early_issue", issue_valid_o, 0);
        step();
        check("wake_first_issue", issue_valid_o, 1);
        check("wake_first_index", issue_index_o, 0);
        check("wake_alloc_ready_back", alloc_ready_o, 1);
        check("wake_alloc_index_back", alloc_index_o, 0);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("wake_drain_cycles", n, ENTRIES);
        check("wake_drain_valid", issue_valid_o, 0);
        check("wake_drain_occ", occupancy_o, 0);

        // Same-cycle wakeup bypass
        drive_alloc(32'h77, 6'd7, 1'b0, 6'd3, 1'b1);
        wake_valid_i = 1'b1;
        wake_tag_i   = 6'd7;
        expect_issue(32'h77, 0);
        step();
        alloc_valid_i = 1'b0;
        wake_valid_i  = 1'b0;
        step();
        check("byp_issue_valid", issue_valid_o, 1);
        check("byp_payload", issue_payload_o, 32'h77);
        step();
        check("byp_sb_empty", exp_q.size(), 0);

        // Backpressure
        issue_ready_i = 1'b0;
        drive_alloc(32'hB0, 6'd1, 1'b1, 6'd2, 1'b1);
        expect_issue(32'hB0, 0);
        step();
        drive_alloc(32'hB1, 6'd1, 1'b1, 6'd2, 1'b1);
        expect_issue(32'hB1, 1);
        step();
        alloc_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", issue_valid_o, 1);
            check("bp_payload", issue_payload_o, 32'hB0);
            check("bp_index", issue_index_o, 0);
            check("bp_occ", occupancy_o, 1);
            step();
        end
        issue_ready_i = 1'b1;
        step();
        check("bp_release_valid", issue_valid_o, 1);
        check("bp_release_payload", issue_payload_o, 32'hB1);
        check("bp_release_index", issue_index_o, 1);
        step();
        check("bp_done_valid", issue_valid_o, 0);
        check("bp_sb_empty", exp_q.size(), 0);

        // Flush with a held issue and a same-cycle alloc
        issue_ready_i = 1'b0;
        drive_alloc(32'hF0, 6'd1, 1'b1, 6'd2, 1'b1);
        step();
        drive_alloc(32'hF1, 6'd1, 1'b1, 6'd2, 1'b1);
        step();
        check("fl_pre_valid", issue_valid_o, 1);
        drive_alloc(32'hF2, 6'd1, 1'b1, 6'd2, 1'b1);
        flush_i = 1'b1;
        #1;
        check("fl_alloc_ready_low", alloc_ready_o, 0);
        step();
        flush_i       = 1'b0;
        alloc_valid_i = 1'b0;
        check("fl_occ", occupancy_o, 0);
        check("fl_issue_valid", issue_valid_o, 0);
        check("fl_alloc_index", alloc_index_o, 0);
        check("fl_issue_payload", issue_payload_o, 0);
        check("fl_issue_index", issue_index_o, 0);
        issue_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_stays_empty", issue_valid_o, 0);
        end
        check("fl_occ_after", occupancy_o, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
